lsu_wbp: RTL and testbench
==========================

// Module: lsu_wbp
// PURPOSE
//  Parametrised load/store unit between exec and the register-file writeback (xrs) in the KCP53K cpu2 pipeline.
//  Converts one 64-bit load/store into 1..N pipelined Wishbone B4 beats on a DATA_W-bit bus.
//  Loads are sign- or zero-extended; ALU results (nomem) pass through to writeback in one cycle.
//  Asserts busy_o to stall exec; reports misaligned accesses instead of issuing them.
// PARAMETERS
//  DATA_W  16  Wishbone data width; legal values 16, 32, 64. SEL_W=DATA_W/8, LSB=log2(SEL_W).
//  ADDR_W  64  Wishbone address width. Register data is fixed at 64 bits.
// PORTS
//  clk_i        in   1       clock; all state updates on rising edge
//  reset_i      in   1       asynchronous, active-high reset
//  addr_i       in   64      effective address (mem) or ALU result (nomem)
//  dat_i        in   64      store data (rs2)
//  we_i         in   1       1=store, 0=load (valid with mem_i)
//  nomem_i      in   1       non-memory op: write addr_i to rd
//  mem_i        in   1       memory op; wins if nomem_i is also high
//  xrs_rwe_i    in   3       size/extension code, see BEHAVIOUR
//  xrs_rd_i     in   5       destination register
//  busy_o       out  1       1 = inputs not accepted this cycle
//  rwe_o        out  3       writeback code to xrs; 0 = no write
//  dat_o        out  64      writeback data
//  rd_o         out  5       writeback register
//  misalign_o   out  1       one-cycle pulse: misaligned access dropped
//  wbmcyc_o     out  1       bus cycle active
//  wbmstb_o     out  1       beat request
//  wbmwe_o      out  1       write enable
//  wbmadr_o     out  ADDR_W  byte address of current beat
//  wbmsel_o     out  SEL_W   byte-lane select
//  wbmdat_o     out  DATA_W  write data
//  wbmack_i     in   1       beat completion (one per beat)
//  wbmstall_i   in   1       slave cannot accept beat this cycle
//  wbmdat_i     in   DATA_W  read data, valid with wbmack_i
// BEHAVIOUR
//  xrs_rwe codes: 0 none, 1 S8, 2 S16, 3 S32, 4 D64, 5 U8, 6 U16, 7 U32. Stores use size only; code 0 with mem_i = no-op.
//  Reset: every output 0, FSM to IDLE, counters 0; an in-flight transaction is abandoned (cyc/stb drop at once).
//  Accept when busy_o=0 at a rising edge. Bubble (mem_i=nomem_i=0): next cycle rwe_o=0.
//  nomem: registered, 1-cycle latency: rwe_o=xrs_rwe_i, dat_o=addr_i, rd_o=xrs_rd_i; busy_o stays 0 (back-to-back OK).
//  mem: addr not aligned to access size -> misalign_o=1 next cycle, rwe_o=0, no bus activity, busy_o stays 0.
//  FSM IDLE->ISSUE on aligned mem accept; busy_o=1 combinationally-registered from next cycle until DONE.
//  Beats NB = max(1, size/SEL_W). Sub-bus-width access: 1 beat, wbmadr_o=addr with low LSB bits cleared,
//   wbmsel_o lanes = addr[LSB-1:0]..+size-1, store data replicated across lanes.
//  Multi-beat: beat k address = addr + k*SEL_W, little-endian: beat 0 carries dat_i[DATA_W-1:0], sel all ones.
//  ISSUE: cyc=stb=1; beat counter advances on each edge with stall=0; after last unstalled beat stb=0 -> WAIT.
//  ACK counter independent; ack in same cycle as an issue is legal; acks beyond NB are ignored.
//  WAIT (cyc=1,stb=0) until ack count = NB -> DONE. Load data shifted into 64-bit assembly reg on each ack.
//  DONE (one cycle): cyc=0, busy_o=0; load: rwe_o=code, rd_o=rd, dat_o=extended lanes; store: rwe_o=0. ->IDLE.
//  A new op may be accepted in DONE cycle. Latency, no stall: 1-beat load writeback 3 cycles after accept.
//  wbmwe_o, wbmadr_o, wbmsel_o, wbmdat_o hold steady while stb=1 and stall=1.
// STRUCTURE
//  Shared header lsu_pkg: XRWE_* codes, size decode function, FSM state encodings (IDLE/ISSUE/WAIT/DONE).
//  Sub-module lsu_lane (combinational): lane select, store replication, load lane extract + sign/zero extend.
//  Top: FSM, beat/ack counters, address incrementer, load assembly register, writeback registers.
// TESTING
//  nomem addr_i=0x100, rwe=4, rd=1 -> next cycle rwe_o=4, rd_o=1, dat_o=0x100; busy_o never 1.
//  DATA_W=16 SD dat_i=0x200 @0, no stall -> 4 beats adr 0,2,4,6 data 0x0200,0,0,0 sel 2'b11, we=1; then rwe_o=0.
//  DATA_W=16 LB (code 1) @3, ack dat 0x80AA -> sel 2'b10; dat_o=0xFFFF_FFFF_FFFF_FF80; LBU (5) -> 0x80.
//  DATA_W=32 LD @8 with stall high 2 cycles on beat 1, acks 0x11223344,0x55667788 -> dat_o=0x5566778811223344.
//  DATA_W=64 LW @2 -> misalign_o pulse, wbmcyc_o stays 0, rwe_o=0; next nomem accepted immediately.
//  reset_i asserted between beats of a 4-beat store -> cyc/stb/busy_o/rwe_o 0 same cycle; post-reset load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: writeback codes, size decode, FSM states.
package lsu_pkg;

    // Writeback / access size codes on xrs_rwe.
    localparam logic [2:0] XRWE_NONE = 3'd0;
    localparam logic [2:0] XRWE_S8   = 3'd1;
    localparam logic [2:0] XRWE_S16  = 3'd2;
    localparam logic [2:0] XRWE_S32  = 3'd3;
    localparam logic [2:0] XRWE_D64  = 3'd4;
    localparam logic [2:0] XRWE_U8   = 3'd5;
    localparam logic [2:0] XRWE_U16  = 3'd6;
    localparam logic [2:0] XRWE_U32  = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } lsu_state_e;

    // Access size in bytes for a code; 0 for XRWE_NONE.
    function automatic logic [3:0] xrwe_size(input logic [2:0] code);
        logic [3:0] sz;
        sz = 4'd0;
        case (code)
            XRWE_S8,  XRWE_U8:  sz = 4'd1;
            XRWE_S16, XRWE_U16: sz = 4'd2;
            XRWE_S32, XRWE_U32: sz = 4'd4;
            XRWE_D64:           sz = 4'd8;
            default:            sz = 4'd0;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane helper: lane select and store replication for the bus side,
// lane extract plus sign/zero extension for the writeback side.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [3:0]          w_size_i,
    input  logic [2:0]          w_off_i,
    input  logic [63:0]         w_src_i,
    output logic [DATA_W/8-1:0] sel_o,
    output logic [DATA_W-1:0]   wdat_o,
    input  logic [2:0]          r_code_i,
    input  logic [2:0]          r_off_i,
    input  logic [63:0]         r_dat_i,
    output logic [63:0]         r_dat_o
);

    localparam int unsigned SEL_W = DATA_W / 8;

    logic [63:0] r_sh;

    // Lanes off..off+size-1 are enabled; store bytes repeat every `size` lanes.
    always_comb begin
        sel_o  = '0;
        wdat_o = '0;
        for (int j = 0; j < SEL_W; j++) begin
            sel_o[j] = (j >= int'(w_off_i)) && (j < int'(w_off_i) + int'(w_size_i));
            wdat_o[j*8 +: 8] = w_src_i[(j & (int'(w_size_i) - 1))*8 +: 8];
        end
    end

    // Shift the addressed lanes down to bit 0, then extend to 64 bits.
    always_comb begin
        r_sh    = r_dat_i >> {r_off_i, 3'b000};
        r_dat_o = r_sh;
        unique case (r_code_i)
            XRWE_S8:  r_dat_o = {{56{r_sh[7]}}, r_sh[7:0]};
            XRWE_S16: r_dat_o = {{48{r_sh[15]}}, r_sh[15:0]};
            XRWE_S32: r_dat_o = {{32{r_sh[31]}}, r_sh[31:0]};
            XRWE_U8:  r_dat_o = {56'd0, r_sh[7:0]};
            XRWE_U16: r_dat_o = {48'd0, r_sh[15:0]};
            XRWE_U32: r_dat_o = {32'd0, r_sh[31:0]};
            default:  r_dat_o = r_sh;
        endcase
    end

endmodule

// File: rtl/lsu_wbp.sv
// Load/store unit: splits a 64-bit access into pipelined Wishbone beats and
// returns load/ALU results to the register-file writeback.
module lsu_wbp
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [63:0]           addr_i,
    input  logic [63:0]           dat_i,
    input  logic                  we_i,
    input  logic                  nomem_i,
    input  logic                  mem_i,
    input  logic [2:0]            xrs_rwe_i,
    input  logic [4:0]            xrs_rd_i,
    output logic                  busy_o,
    output logic [2:0]            rwe_o,
    output logic [63:0]           dat_o,
    output logic [4:0]            rd_o,
    output logic                  misalign_o,
    output logic                  wbmcyc_o,
    output logic                  wbmstb_o,
    output logic                  wbmwe_o,
    output logic [ADDR_W-1:0]     wbmadr_o,
    output logic [DATA_W/8-1:0]   wbmsel_o,
    output logic [DATA_W-1:0]     wbmdat_o,
    input  logic                  wbmack_i,
    input  logic                  wbmstall_i,
    input  logic [DATA_W-1:0]     wbmdat_i
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned LSB   = $clog2(SEL_W);
    localparam logic [3:0] SEL_B  = 4'(SEL_W);
    localparam logic [ADDR_W-1:0] ADR_STEP = ADDR_W'(SEL_W);

    lsu_state_e          state_q;
    logic                cyc_q, stb_q, we_q, misalign_q;
    logic [ADDR_W-1:0]   adr_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   wdat_q;
    logic [63:0]         store_q, asm_q, dat_q;
    logic [3:0]          bcnt_q, acnt_q, nb_q, size_q;
    logic [2:0]          code_q, off_q, rwe_q;
    logic [4:0]          rdh_q, rd_q;

    logic                busy, accept, op_mem, op_nomem, start, in_misalign;
    logic                beat_go, last_beat, ack_ok;
    logic [3:0]          in_size, size_mask, in_nb, acnt_d, w_size;
    logic [2:0]          in_off;
    logic [63:0]         asm_d, store_nx, w_src, lane_rdat;
    logic [ADDR_W-1:0]   adr_start;
    logic [SEL_W-1:0]    lane_sel;
    logic [DATA_W-1:0]   lane_wdat;

    // Decode the incoming op and the per-cycle beat/ack events.
    always_comb begin
        busy        = (state_q == StIssue) || (state_q == StWait);
        accept      = !busy;
        in_size     = xrwe_size(xrs_rwe_i);
        size_mask   = in_size - 4'd1;
        in_misalign = ({1'b0, addr_i[2:0]} & size_mask) != 4'd0;
        in_nb       = (in_size > SEL_B) ? (in_size >> LSB) : 4'd1;
        in_off      = '0;
        in_off[LSB-1:0] = addr_i[LSB-1:0];
        adr_start   = addr_i[ADDR_W-1:0] & ~(ADR_STEP - 1'b1);
        // A memory op takes priority over nomem; code 0 with mem_i is a no-op.
        op_mem      = accept && mem_i && (xrs_rwe_i != XRWE_NONE);
        op_nomem    = accept && !mem_i && nomem_i;
        start       = op_mem && !in_misalign;

        beat_go     = (state_q == StIssue) && !wbmstall_i;
        last_beat   = (bcnt_q + 4'd1) == nb_q;
        ack_ok      = busy && wbmack_i && (acnt_q != nb_q);
        acnt_d      = ack_ok ? acnt_q + 4'd1 : acnt_q;

        asm_d = asm_q;
        if (ack_ok) begin
            for (int k = 0; k < 64 / DATA_W; k++) begin
                if (acnt_q == 4'(k)) asm_d[k*DATA_W +: DATA_W] = wbmdat_i;
            end
        end

        store_nx = store_q >> DATA_W;
        w_size   = start ? in_size : size_q;
        w_src    = start ? dat_i : store_nx;
    end

    lsu_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .w_size_i (w_size),
        .w_off_i  (in_off),
        .w_src_i  (w_src),
        .sel_o    (lane_sel),
        .wdat_o   (lane_wdat),
        .r_code_i (code_q),
        .r_off_i  (off_q),
        .r_dat_i  (asm_d),
        .r_dat_o  (lane_rdat)
    );

    // FSM, beat/ack counters, bus outputs and writeback registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            misalign_q <= 1'b0;
            adr_q      <= '0;
            sel_q      <= '0;
            wdat_q     <= '0;
            store_q    <= '0;
            asm_q      <= '0;
            dat_q      <= '0;
            bcnt_q     <= '0;
            acnt_q     <= '0;
            nb_q       <= '0;
            size_q     <= '0;
            code_q     <= '0;
            off_q      <= '0;
            rwe_q      <= '0;
            rdh_q      <= '0;
            rd_q       <= '0;
        end else begin
            misalign_q <= op_mem && in_misalign;
            rwe_q      <= XRWE_NONE;
            if (op_nomem) begin
                rwe_q <= xrs_rwe_i;
                dat_q <= addr_i;
                rd_q  <= xrs_rd_i;
            end

            if (start) begin
                acnt_q <= '0;
                asm_q  <= '0;
            end else begin
                acnt_q <= acnt_d;
                asm_q  <= asm_d;
            end

            unique case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    if (start) begin
                        state_q <= StIssue;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= we_i;
                        adr_q   <= adr_start;
                        sel_q   <= lane_sel;
                        wdat_q  <= lane_wdat;
                        store_q <= dat_i;
                        bcnt_q  <= '0;
                        nb_q    <= in_nb;
                        size_q  <= in_size;
                        code_q  <= xrs_rwe_i;
                        off_q   <= in_off;
                        rdh_q   <= xrs_rd_i;
                    end
                end
                StIssue: begin
                    if (beat_go) begin
                        if (last_beat) begin
                            stb_q   <= 1'b0;
                            state_q <= StWait;
                        end else begin
                            bcnt_q  <= bcnt_q + 4'd1;
                            adr_q   <= adr_q + ADR_STEP;
                            store_q <= store_nx;
                            wdat_q  <= lane_wdat;
                        end
                    end
                end
                StWait: begin
                    if (acnt_d == nb_q) begin
                        cyc_q   <= 1'b0;
                        state_q <= StDone;
                        if (!we_q) begin
                            rwe_q <= code_q;
                            rd_q  <= rdh_q;
                            dat_q <= lane_rdat;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o     = busy;
    assign rwe_o      = rwe_q;
    assign dat_o      = dat_q;
    assign rd_o       = rd_q;
    assign misalign_o = misalign_q;
    assign wbmcyc_o   = cyc_q;
    assign wbmstb_o   = stb_q;
    assign wbmwe_o    = we_q;
    assign wbmadr_o   = adr_q;
    assign wbmsel_o   = sel_q;
    assign wbmdat_o   = wdat_q;

endmodule

// File: tb/tb_lsu_wbp.sv
// Directed bench for lsu_wbp at DATA_W 16, 32 and 64.
module tb_lsu_wbp;

    logic clk = 1'b0;
    logic reset;
    logic [63:0] addr, dat;
    logic we, nomem;
    logic [2:0] xrwe;
    logic [4:0] xrd;
    int errors = 0;
    int checks = 0;

    logic m16, busy16, mis16, cyc16, stb16, we16, ack16, stall16;
    logic [2:0] rwe16;
    logic [63:0] dato16, adr16;
    logic [4:0] rd16;
    logic [1:0] sel16;
    logic [15:0] wdat16, rdat16;

    logic m32, busy32, mis32, cyc32, stb32, we32, ack32, stall32;
    logic [2:0] rwe32;
    logic [63:0] dato32, adr32;
    logic [4:0] rd32;
    logic [3:0] sel32;
    logic [31:0] wdat32, rdat32;

    logic m64, busy64, mis64, cyc64, stb64, we64, ack64, stall64;
    logic [2:0] rwe64;
    logic [63:0] dato64, adr64;
    logic [4:0] rd64;
    logic [7:0] sel64;
    logic [63:0] wdat64, rdat64;

    always #5 clk = ~clk;

    lsu_wbp #(.DATA_W(16), .ADDR_W(64)) u16 (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .dat_i(dat), .we_i(we),
        .nomem_i(nomem), .mem_i(m16), .xrs_rwe_i(xrwe), .xrs_rd_i(xrd),
        .busy_o(busy16), .rwe_o(rwe16), .dat_o(dato16), .rd_o(rd16), .misalign_o(mis16),
        .wbmcyc_o(cyc16), .wbmstb_o(stb16), .wbmwe_o(we16), .wbmadr_o(adr16),
        .wbmsel_o(sel16), .wbmdat_o(wdat16), .wbmack_i(ack16), .wbmstall_i(stall16),
        .wbmdat_i(rdat16)
    );

    lsu_wbp #(.DATA_W(32), .ADDR_W(64)) u32 (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .dat_i(dat), .we_i(we),
        .nomem_i(nomem), .mem_i(m32), .xrs_rwe_i(xrwe), .xrs_rd_i(xrd),
        .busy_o(busy32), .rwe_o(rwe32), .dat_o(dato32), .rd_o(rd32), .misalign_o(mis32),
        .wbmcyc_o(cyc32), .wbmstb_o(stb32), .wbmwe_o(we32), .wbmadr_o(adr32),
        .wbmsel_o(sel32), .wbmdat_o(wdat32), .wbmack_i(ack32), .wbmstall_i(stall32),
        .wbmdat_i(rdat32)
    );

    lsu_wbp #(.DATA_W(64), .ADDR_W(64)) u64 (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .dat_i(dat), .we_i(we),
        .nomem_i(nomem), .mem_i(m64), .xrs_rwe_i(xrwe), .xrs_rd_i(xrd),
        .busy_o(busy64), .rwe_o(rwe64), .dat_o(dato64), .rd_o(rd64), .misalign_o(mis64),
        .wbmcyc_o(cyc64), .wbmstb_o(stb64), .wbmwe_o(we64), .wbmadr_o(adr64),
        .wbmsel_o(sel64), .wbmdat_o(wdat64), .wbmack_i(ack64), .wbmstall_i(stall64),
        .wbmdat_i(rdat64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy16, rwe16, dato16, rd16, mis16, cyc16, stb16, we16, adr16, sel16, wdat16} !== '0) begin
            errors++;
            $display("FAIL reset16 got %h want 0",
                     {busy16, rwe16, dato16, rd16, mis16, cyc16, stb16, we16, adr16, sel16, wdat16});
        end
        checks++;
        if ({busy32, rwe32, dato32, rd32, mis32, cyc32, stb32, we32, adr32, sel32, wdat32} !== '0) begin
            errors++;
            $display("FAIL reset32 got %h want 0",
                     {busy32, rwe32, dato32, rd32, mis32, cyc32, stb32, we32, adr32, sel32, wdat32});
        end
        checks++;
        if ({busy64, rwe64, dato64, rd64, mis64, cyc64, stb64, we64, adr64, sel64, wdat64} !== '0) begin
            errors++;
            $display("FAIL reset64 got %h want 0",
                     {busy64, rwe64, dato64, rd64, mis64, cyc64, stb64, we64, adr64, sel64, wdat64});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nomem();
        nomem = 1'b1; addr = 64'h100; xrwe = 3'd4; xrd = 5'd1;
        tick();
        checks++;
        if ({rwe16, rd16, dato16, busy16} !== {3'd4, 5'd1, 64'h100, 1'b0}) begin
            errors++;
            $display("FAIL nomem1 got rwe=%0d rd=%0d dat=%h busy=%b want 4 1 100 0",
                     rwe16, rd16, dato16, busy16);
        end
        addr = 64'h200; xrwe = 3'd7; xrd = 5'd2;
        tick();
        checks++;
        if ({rwe16, rd16, dato16, busy16} !== {3'd7, 5'd2, 64'h200, 1'b0}) begin
            errors++;
            $display("FAIL nomem_b2b got rwe=%0d rd=%0d dat=%h busy=%b want 7 2 200 0",
                     rwe16, rd16, dato16, busy16);
        end
        nomem = 1'b0;
        tick();
        checks++;
        if ({rwe16, busy16} !== 4'b0000) begin
            errors++;
            $display("FAIL bubble got rwe=%0d busy=%b want 0 0", rwe16, busy16);
        end
        // mem wins over nomem: misaligned halfword must be dropped, not written back
        nomem = 1'b1; m16 = 1'b1; addr = 64'h301; xrwe = 3'd2;
        tick();
        nomem = 1'b0; m16 = 1'b0;
        checks++;
        if ({mis16, rwe16, cyc16} !== {1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL mem_wins got mis=%b rwe=%0d cyc=%b want 1 0 0", mis16, rwe16, cyc16);
        end
        tick();
    endtask

    task automatic test_store16();
        logic [15:0] wexp;
        addr = 64'h0; dat = 64'h200; we = 1'b1; xrwe = 3'd4; xrd = 5'd2; m16 = 1'b1;
        tick();
        m16 = 1'b0; ack16 = 1'b0;
        checks++;
        if ({cyc16, stb16, we16, busy16, adr16, sel16, wdat16} !== {4'b1111, 64'h0, 2'b11, 16'h0200}) begin
            errors++;
            $display("FAIL sd_beat0 got cyc=%b stb=%b we=%b busy=%b adr=%h sel=%b dat=%h",
                     cyc16, stb16, we16, busy16, adr16, sel16, wdat16);
        end
        tick();
        for (int k = 1; k < 4; k++) begin
            ack16 = 1'b1;
            wexp = 16'h0;
            checks++;
            if ({stb16, we16, adr16, sel16, wdat16} !== {2'b11, 64'(2 * k), 2'b11, wexp}) begin
                errors++;
                $display("FAIL sd_beat%0d got stb=%b we=%b adr=%h sel=%b dat=%h want adr=%0d dat=%h",
                         k, stb16, we16, adr16, sel16, wdat16, 2 * k, wexp);
            end
            tick();
        end
        checks++;
        if ({cyc16, stb16, busy16} !== 3'b101) begin
            errors++;
            $display("FAIL sd_wait got cyc=%b stb=%b busy=%b want 1 0 1", cyc16, stb16, busy16);
        end
        tick();
        ack16 = 1'b0;
        checks++;
        if ({cyc16, busy16, rwe16} !== 5'b0) begin
            errors++;
            $display("FAIL sd_done got cyc=%b busy=%b rwe=%0d want 0 0 0", cyc16, busy16, rwe16);
        end
        we = 1'b0;
        tick();
    endtask

    task automatic test_load16();
        addr = 64'h3; xrwe = 3'd1; we = 1'b0; xrd = 5'd5; m16 = 1'b1;
        tick();
        m16 = 1'b0;
        checks++;
        if ({cyc16, stb16, we16, busy16, adr16, sel16} !== {4'b1101, 64'h2, 2'b10}) begin
            errors++;
            $display("FAIL lb_issue got cyc=%b stb=%b we=%b busy=%b adr=%h sel=%b want 1 1 0 1 2 10",
                     cyc16, stb16, we16, busy16, adr16, sel16);
        end
        tick();
        ack16 = 1'b1; rdat16 = 16'h80AA;
        tick();
        ack16 = 1'b0; rdat16 = 16'h0;
        checks++;
        if ({rwe16, rd16, dato16, busy16, cyc16} !== {3'd1, 5'd5, 64'hFFFF_FFFF_FFFF_FF80, 2'b00}) begin
            errors++;
            $display("FAIL lb_wb got rwe=%0d rd=%0d dat=%h busy=%b cyc=%b want 1 5 ffffffffffffff80 0 0",
                     rwe16, rd16, dato16, busy16, cyc16);
        end
        // new op accepted in the DONE cycle
        xrwe = 3'd5; m16 = 1'b1;
        tick();
        m16 = 1'b0;
        checks++;
        if ({busy16, rwe16} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL lbu_accept got busy=%b rwe=%0d want 1 0", busy16, rwe16);
        end
        tick();
        ack16 = 1'b1; rdat16 = 16'h80AA;
        tick();
        ack16 = 1'b0; rdat16 = 16'h0;
        checks++;
        if ({rwe16, dato16} !== {3'd5, 64'h80}) begin
            errors++;
            $display("FAIL lbu_wb got rwe=%0d dat=%h want 5 80", rwe16, dato16);
        end
        tick();
    endtask

    task automatic test_stall32();
        addr = 64'h8; xrwe = 3'd4; we = 1'b0; xrd = 5'd6; m32 = 1'b1;
        tick();
        m32 = 1'b0;
        checks++;
        if ({cyc32, stb32, busy32, adr32, sel32} !== {3'b111, 64'h8, 4'hF}) begin
            errors++;
            $display("FAIL ld32_beat0 got cyc=%b stb=%b busy=%b adr=%h sel=%h",
                     cyc32, stb32, busy32, adr32, sel32);
        end
        tick();
        checks++;
        if ({stb32, adr32} !== {1'b1, 64'hC}) begin
            errors++;
            $display("FAIL ld32_beat1 got stb=%b adr=%h want 1 c", stb32, adr32);
        end
        stall32 = 1'b1; ack32 = 1'b1; rdat32 = 32'h1122_3344;
        tick();
        ack32 = 1'b0; rdat32 = 32'h0;
        checks++;
        if ({stb32, adr32} !== {1'b1, 64'hC}) begin
            errors++;
            $display("FAIL ld32_hold got stb=%b adr=%h want 1 c", stb32, adr32);
        end
        tick();
        stall32 = 1'b0;
        tick();
        checks++;
        if ({cyc32, stb32} !== 2'b10) begin
            errors++;
            $display("FAIL ld32_wait got cyc=%b stb=%b want 1 0", cyc32, stb32);
        end
        ack32 = 1'b1; rdat32 = 32'h5566_7788;
        tick();
        ack32 = 1'b0; rdat32 = 32'h0;
        checks++;
        if ({rwe32, rd32, dato32, busy32} !== {3'd4, 5'd6, 64'h5566_7788_1122_3344, 1'b0}) begin
            errors++;
            $display("FAIL ld32_wb got rwe=%0d rd=%0d dat=%h busy=%b want 4 6 5566778811223344 0",
                     rwe32, rd32, dato32, busy32);
        end
        tick();
    endtask

    task automatic test_misalign64();
        addr = 64'h2; xrwe = 3'd3; we = 1'b0; xrd = 5'd7; m64 = 1'b1;
        tick();
        m64 = 1'b0; nomem = 1'b1; addr = 64'h55; xrwe = 3'd4; xrd = 5'd9;
        checks++;
        if ({mis64, cyc64, rwe64, busy64} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL lw64_mis got mis=%b cyc=%b rwe=%0d busy=%b want 1 0 0 0",
                     mis64, cyc64, rwe64, busy64);
        end
        tick();
        nomem = 1'b0;
        checks++;
        if ({mis64, cyc64, rwe64, rd64, dato64} !== {2'b00, 3'd4, 5'd9, 64'h55}) begin
            errors++;
            $display("FAIL lw64_next got mis=%b cyc=%b rwe=%0d rd=%0d dat=%h want 0 0 4 9 55",
                     mis64, cyc64, rwe64, rd64, dato64);
        end
        tick();
    endtask

    task automatic test_reset_midburst();
        addr = 64'h10; dat = 64'h1111_2222_3333_4444; we = 1'b1; xrwe = 3'd4; m16 = 1'b1;
        tick();
        m16 = 1'b0;
        tick();
        checks++;
        if ({busy16, cyc16, stb16, adr16, wdat16} !== {3'b111, 64'h12, 16'h3333}) begin
            errors++;
            $display("FAIL mid_beat1 got busy=%b cyc=%b stb=%b adr=%h dat=%h want 1 1 1 12 3333",
                     busy16, cyc16, stb16, adr16, wdat16);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({cyc16, stb16, busy16, rwe16, we16} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset got cyc=%b stb=%b busy=%b rwe=%0d we=%b want 0",
                     cyc16, stb16, busy16, rwe16, we16);
        end
        #2;
        reset = 1'b0;
        tick();
        addr = 64'h4; xrwe = 3'd2; xrd = 5'd3; we = 1'b0; m16 = 1'b1;
        tick();
        m16 = 1'b0;
        checks++;
        if ({cyc16, stb16, we16, adr16, sel16} !== {3'b110, 64'h4, 2'b11}) begin
            errors++;
            $display("FAIL post_issue got cyc=%b stb=%b we=%b adr=%h sel=%b want 1 1 0 4 11",
                     cyc16, stb16, we16, adr16, sel16);
        end
        tick();
        ack16 = 1'b1; rdat16 = 16'h8001;
        tick();
        ack16 = 1'b0; rdat16 = 16'h0;
        checks++;
        if ({rwe16, rd16, dato16} !== {3'd2, 5'd3, 64'hFFFF_FFFF_FFFF_8001}) begin
            errors++;
            $display("FAIL post_wb got rwe=%0d rd=%0d dat=%h want 2 3 ffffffffffff8001",
                     rwe16, rd16, dato16);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; addr = '0; dat = '0; we = 1'b0; nomem = 1'b0; xrwe = '0; xrd = '0;
        m16 = 1'b0; ack16 = 1'b0; stall16 = 1'b0; rdat16 = '0;
        m32 = 1'b0; ack32 = 1'b0; stall32 = 1'b0; rdat32 = '0;
        m64 = 1'b0; ack64 = 1'b0; stall64 = 1'b0; rdat64 = '0;
        test_reset();
        test_nomem();
        test_store16();
        test_load16();
        test_stall32();
        test_misalign64();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
